// File: rtl/ma_mem_access_unit_if.sv
// ma_mem_access_unit_if: MA-stage request/response signals and the data-memory bus.
interface ma_mem_access_unit_if;
  logic        mem_read_ma_in;
  logic        mem_write_ma_in;
  logic [2:0]  funct3_ma_in;
  logic [31:0] alu_out_ma_in;
  logic [31:0] store_data_ma_in;
  logic        dmem_busywait;
  logic [31:0] dmem_readdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_writedata;
  logic [3:0]  dmem_byte_en;
  logic [31:0] mem_data_ma_out;
  logic        busywait;
  logic        misaligned_out;
  logic        bus_error_out;
  modport slave (
    input  mem_read_ma_in, mem_write_ma_in, funct3_ma_in, alu_out_ma_in, store_data_ma_in,
           dmem_busywait, dmem_readdata,
    output dmem_read, dmem_write, dmem_addr, dmem_writedata, dmem_byte_en,
           mem_data_ma_out, busywait, misaligned_out, bus_error_out
  );
  modport master (
    output mem_read_ma_in, mem_write_ma_in, funct3_ma_in, alu_out_ma_in, store_data_ma_in,
           dmem_busywait, dmem_readdata,
    input  dmem_read, dmem_write, dmem_addr, dmem_writedata, dmem_byte_en,
           mem_data_ma_out, busywait, misaligned_out, bus_error_out
  );
endinterface

// File: rtl/ma_mem_access_unit.sv
// ma_mem_access_unit: MA-stage load/store controller with byte lanes, stall, misalign and timeout flags.
module ma_mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  ma_mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state;
  logic        rd_q, err_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] data_q, cnt;
  logic        req, is_b, is_h, mis, timeout;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] sd, wd, ext;
  logic [15:0] lane;
  always_comb begin
    off     = bus.alu_out_ma_in[1:0];
    sd      = bus.store_data_ma_in;
    req     = bus.mem_read_ma_in | bus.mem_write_ma_in;
    is_b    = bus.funct3_ma_in[1:0] == 2'b00;
    is_h    = bus.funct3_ma_in[1:0] == 2'b01;
    mis     = is_b ? 1'b0 : is_h ? off[0] : off != 2'b00;
    be      = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
    wd      = is_b ? {4{sd[7:0]}} : is_h ? {2{sd[15:0]}} : sd;
    lane    = 16'(bus.dmem_readdata >> {off_q, 3'b000});
    ext     = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
              f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane} : bus.dmem_readdata;
    timeout = TIMEOUT_CYCLES != 0 && cnt + 32'd1 == TIMEOUT_CYCLES;
  end
  // Gated by rst so the stall and flag outputs also fall the moment reset asserts.
  assign bus.busywait        = rst & ((state == IDLE & req & ~mis) | state == WAIT);
  assign bus.misaligned_out  = rst & state == IDLE & req & mis;
  assign bus.mem_data_ma_out = (state == DONE & rd_q) ? data_q : '0;
  assign bus.bus_error_out   = err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      rd_q               <= 1'b0;
      err_q              <= 1'b0;
      f3_q               <= '0;
      off_q              <= '0;
      data_q             <= '0;
      cnt                <= '0;
      bus.dmem_read      <= 1'b0;
      bus.dmem_write     <= 1'b0;
      bus.dmem_addr      <= '0;
      bus.dmem_writedata <= '0;
      bus.dmem_byte_en   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: if (req && !mis) begin
          state              <= WAIT;
          rd_q               <= bus.mem_read_ma_in;
          f3_q               <= bus.funct3_ma_in;
          off_q              <= off;
          cnt                <= '0;
          bus.dmem_read      <= bus.mem_read_ma_in;
          bus.dmem_write     <= ~bus.mem_read_ma_in;
          bus.dmem_addr      <= {bus.alu_out_ma_in[31:2], 2'b00};
          bus.dmem_writedata <= wd;
          bus.dmem_byte_en   <= be;
        end
        WAIT: begin
          cnt <= cnt + 32'd1;
          if (!bus.dmem_busywait || timeout) begin
            state          <= DONE;
            bus.dmem_read  <= 1'b0;
            bus.dmem_write <= 1'b0;
            data_q         <= bus.dmem_busywait ? '0 : ext;
            err_q          <= bus.dmem_busywait;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ma_mem_access_unit.md
Name: ma_mem_access_unit

Overview:
- Memory-access (MA) stage controller between the EX/MA pipeline register and the data memory/cache; sits directly upstream of the MA/WB pipeline register.
- Converts load/store requests into word-aligned memory transactions with byte enables, and holds the pipeline via busywait while the memory is busy.
- Sign- or zero-extends load data and flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before a bus error is declared; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
mem_read_ma_in  input  1  load request for the instruction in MA
mem_write_ma_in  input  1  store request for the instruction in MA
funct3_ma_in  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_out_ma_in  input  32  byte address
store_data_ma_in  input  32  rs2 value
dmem_busywait  input  1  memory busy; high while a transaction is pending
dmem_readdata  input  32  read word from memory
dmem_read  output  1  memory read strobe
dmem_write  output  1  memory write strobe
dmem_addr  output  32  word address; bits [1:0] always 00
dmem_writedata  output  32  lane-replicated store data
dmem_byte_en  output  4  byte-lane enables
mem_data_ma_out  output  32  extended load result, to the MA/WB register
busywait  output  1  pipeline stall, to all pipeline registers
misaligned_out  output  1  one-cycle misaligned-access flag
bus_error_out  output  1  one-cycle timeout flag

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, including the captured data register and the timeout counter.
- A request is present when mem_read_ma_in or mem_write_ma_in is high. If both are high, read wins.
- Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=00.
  - In IDLE, a misaligned request issues no memory access and gives busywait=0 and mem_data_ma_out=0.
  - misaligned_out is combinationally high for that cycle.
- IDLE, aligned request:
  - busywait=1 combinationally in the same cycle.
  - At the edge, register the address, write data and byte enables; go to WAIT.
- WAIT:
  - dmem_read/dmem_write asserted; dmem_* outputs held stable; busywait=1; counter increments each cycle.
  - dmem_busywait=0 at an edge: capture dmem_readdata, go to DONE.
  - Counter reaches TIMEOUT_CYCLES (when nonzero): go to DONE with captured data 0 and a bus_error_out pulse in DONE.
- DONE:
  - Strobes low, busywait=0, mem_data_ma_out valid; the pipeline advances on this edge.
  - Next state is always IDLE, even if request inputs are still high. This prevents re-issue.
- Latency: with memory that drops busywait the cycle after the strobe, the stall is 2 cycles (IDLE, WAIT) and the data is valid in cycle 3.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0] (addr[1:0] is 00 or 10).
  - W: 1111.
- Store data: B replicated to all 4 lanes; H replicated to 2 lanes; W unchanged.
- Load extraction:
  - Select the byte/half by addr[1:0].
  - B and H sign-extend; BU and HU zero-extend.
  - Reserved funct3 values are treated as W.
- mem_data_ma_out is 0 when no load completes in that cycle.
- A reset mid-WAIT aborts the transaction immediately: strobes drop asynchronously.
- dmem_readdata is ignored outside WAIT.

Test Plan:
- LW at 0x100, memory busy 3 cycles returning 0xDEADBEEF -> busywait high for 4 cycles; dmem_addr=0x100, byte_en=1111; DONE gives mem_data_ma_out=0xDEADBEEF; no re-issue.
- LB at 0x103, read word 0x80FF_FF7F -> byte_en=1000, result 0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x102 with data 0x1234ABCD -> dmem_write=1, byte_en=1100, writedata=0xABCDABCD, addr=0x100.
- LW at 0x101 -> no strobe, misaligned_out=1 for one cycle, busywait=0.
- TIMEOUT_CYCLES=4 with dmem_busywait stuck at 1 -> DONE after 4 WAIT cycles; bus_error_out pulse; data 0; back to IDLE.
- rst driven to 0 mid-WAIT -> all outputs 0 immediately; after release, state is IDLE and the next request issues normally.
